// File: rtl/vc_fifo_bank.sv
// Multi-channel virtual-channel FIFO bank: shared steered write port, per-channel registered reads and flags.
// Optional per-channel peak occupancy output when VC_FIFO_WATERMARK_EN is defined.
`timescale 1ns/1ps
module vc_fifo_bank #(
    parameter int DATA_WIDTH  = 6,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_VC      = 2,
    parameter int VC_ID_WIDTH = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               init,
    input  logic                               wr_enable,
    input  logic [VC_ID_WIDTH-1:0]             wr_vc,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic [NUM_VC-1:0]                  rd_enable,
    input  logic [ADDR_WIDTH-1:0]              umbral_empty,
    input  logic [ADDR_WIDTH-1:0]              umbral_full,
    output logic [NUM_VC*DATA_WIDTH-1:0]       data_out,
    output logic [NUM_VC-1:0]                  valid_out,
    output logic [NUM_VC-1:0]                  full,
    output logic [NUM_VC-1:0]                  empty,
    output logic [NUM_VC-1:0]                  almost_full,
    output logic [NUM_VC-1:0]                  almost_empty,
    output logic [NUM_VC*(ADDR_WIDTH+1)-1:0]   count,
    output logic [NUM_VC-1:0]                  error,
    output logic                               vc_error
`ifdef VC_FIFO_WATERMARK_EN
    ,
    output logic [NUM_VC*(ADDR_WIDTH+1)-1:0]   peak_count
`endif
);
    localparam int CW      = ADDR_WIDTH + 1;
    localparam int DEPTH   = 1 << ADDR_WIDTH;
    localparam int NUM_IDS = 1 << VC_ID_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Lookup of which wr_vc encodings name a real channel; avoids a compare that is constant for some parameter sets.
    logic [NUM_IDS-1:0] vc_ok_mask;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IDS; gi++) begin : g_vc_mask
            assign vc_ok_mask[gi] = (gi < NUM_VC);
        end
    endgenerate

    logic [CW-1:0] af_level;
    logic [CW-1:0] ae_level;
    assign af_level = DEPTH_C - {1'b0, umbral_full};
    assign ae_level = {1'b0, umbral_empty};

    logic vc_err_q, vc_err_d;

    always_comb begin
        vc_err_d = vc_err_q | (wr_enable & ~vc_ok_mask[wr_vc]);
        if (!init) begin
            vc_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc_err_q <= 1'b0;
        end else begin
            vc_err_q <= vc_err_d;
        end
    end

    assign vc_error = vc_err_q;

    generate
        for (gi = 0; gi < NUM_VC; gi++) begin : g_ch
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
            logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]         cnt_q, cnt_d;
            logic [DATA_WIDTH-1:0] dout_q, dout_d;
            logic                  vld_q, vld_d;
            logic                  err_q, err_d;
            logic                  wr_hit, wr_acc, rd_acc, mem_we;

            always_comb begin
                wr_hit   = wr_enable && (wr_vc == VC_ID_WIDTH'(gi));
                rd_acc   = rd_enable[gi] && (cnt_q != '0);
                // A full channel still accepts a write when the same cycle frees a slot.
                wr_acc   = wr_hit && ((cnt_q != DEPTH_C) || rd_acc);
                mem_we   = wr_acc && init;
                wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
                rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
                cnt_d    = cnt_q;
                if (wr_acc && !rd_acc) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (rd_acc && !wr_acc) begin
                    cnt_d = cnt_q - CW'(1);
                end
                err_d  = err_q | (wr_hit && !wr_acc) | (rd_enable[gi] && (cnt_q == '0));
                vld_d  = rd_acc;
                dout_d = rd_acc ? mem[rd_ptr_q] : '0;
                if (!init) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    vld_d    = 1'b0;
                    dout_d   = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (mem_we) begin
                    mem[wr_ptr_q] <= data_in;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                    err_q    <= 1'b0;
                    vld_q    <= 1'b0;
                    dout_q   <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                    err_q    <= err_d;
                    vld_q    <= vld_d;
                    dout_q   <= dout_d;
                end
            end

            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = dout_q;
            assign valid_out[gi]    = vld_q;
            assign count[gi*CW +: CW] = cnt_q;
            assign error[gi]        = err_q;
            assign full[gi]         = (cnt_q == DEPTH_C);
            assign empty[gi]        = (cnt_q == '0);
            assign almost_full[gi]  = (cnt_q >= af_level);
            assign almost_empty[gi] = (cnt_q <= ae_level) && (cnt_q != '0);

`ifdef VC_FIFO_WATERMARK_EN
            logic [CW-1:0] peak_q, peak_d;

            always_comb begin
                peak_d = (cnt_d > peak_q) ? cnt_d : peak_q;
                if (!init) begin
                    peak_d = '0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    peak_q <= '0;
                end else begin
                    peak_q <= peak_d;
                end
            end

            assign peak_count[gi*CW +: CW] = peak_q;
`endif
        end
    endgenerate

endmodule
